// File: rtl/counter_checker_pkg.sv
// Shared types and default sizing for the counter sequence checker.
// The match counter is sized for the full legal LOCK_N range (1..15).
package counter_checker_pkg;

  typedef enum logic [1:0] {
    ST_SEED    = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam int DEF_CNT_W  = 4;
  localparam int DEF_ERR_W  = 8;
  localparam int DEF_LOCK_N = 2;
  localparam int MATCH_W    = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
// Once the count reaches its all-ones value it holds there until cleared or reset.
module sat_counter #(
  parameter int width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [width-1:0] count
);

  localparam logic [width-1:0] CNT_MAX = {width{1'b1}};
  localparam logic [width-1:0] CNT_ONE = {{(width-1){1'b0}}, 1'b1};

  logic [width-1:0] count_r;

  // Count register: clear wins over increment, increment stops at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {width{1'b0}};
    end else if (clr) begin
      count_r <= {width{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/counter_checker.sv
// Watches an external counter and its enable, predicts each next value and
// reports mismatches once it has locked onto the sequence.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ERR_W  = DEF_ERR_W,
  parameter int LOCK_N = DEF_LOCK_N
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] counter_in,
  input  logic             resync,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] error_count,
  output logic [CNT_W-1:0] last_bad,
  output logic [CNT_W-1:0] last_exp
);

  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [MATCH_W-1:0] LOCK_TGT  = MATCH_W'(LOCK_N);
  localparam logic [MATCH_W-1:0] MATCH_ONE = {{(MATCH_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   prev_r;
  logic               prev_en_r;
  logic [MATCH_W-1:0] match_cnt_r;
  logic [MATCH_W-1:0] match_nxt_s;
  logic [MATCH_W-1:0] match_inc_s;
  logic [CNT_W-1:0]   exp_s;
  logic               match_s;
  logic               err_evt_s;
  logic               locked_r;
  logic               error_r;
  logic [CNT_W-1:0]   last_bad_r;
  logic [CNT_W-1:0]   last_exp_r;

  function automatic logic [CNT_W-1:0] predict(input logic [CNT_W-1:0] prev,
                                               input logic             en);
    logic [CNT_W-1:0] nxt;
    if (en) begin
      nxt = prev + CNT_ONE;
    end else begin
      nxt = prev;
    end
    return nxt;
  endfunction

  assign exp_s       = predict(prev_r, prev_en_r);
  assign match_s     = (counter_in == exp_s);
  assign match_inc_s = match_cnt_r + MATCH_ONE;

  // Next-state logic; resync dominates and suppresses any same-cycle mismatch.
  always_comb begin
    state_nxt_s = state_r;
    match_nxt_s = match_cnt_r;
    err_evt_s   = 1'b0;
    if (resync) begin
      state_nxt_s = ST_SEED;
      match_nxt_s = {MATCH_W{1'b0}};
    end else begin
      case (state_r)
        ST_SEED: begin
          state_nxt_s = ST_LOCKING;
          match_nxt_s = {MATCH_W{1'b0}};
        end
        ST_LOCKING: begin
          if (match_s) begin
            match_nxt_s = match_inc_s;
            if (match_inc_s >= LOCK_TGT) begin
              state_nxt_s = ST_LOCKED;
            end else begin
              state_nxt_s = ST_LOCKING;
            end
          end else begin
            match_nxt_s = {MATCH_W{1'b0}};
            state_nxt_s = ST_LOCKING;
          end
        end
        ST_LOCKED: begin
          if (match_s) begin
            state_nxt_s = ST_LOCKED;
          end else begin
            err_evt_s   = 1'b1;
            match_nxt_s = {MATCH_W{1'b0}};
            state_nxt_s = ST_LOCKING;
          end
        end
        default: begin
          state_nxt_s = ST_SEED;
          match_nxt_s = {MATCH_W{1'b0}};
        end
      endcase
    end
  end

  // State, history and registered outputs; prev/enable are sampled every edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_SEED;
      prev_r      <= {CNT_W{1'b0}};
      prev_en_r   <= 1'b0;
      match_cnt_r <= {MATCH_W{1'b0}};
      locked_r    <= 1'b0;
      error_r     <= 1'b0;
      last_bad_r  <= {CNT_W{1'b0}};
      last_exp_r  <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      prev_r      <= counter_in;
      prev_en_r   <= enable;
      match_cnt_r <= match_nxt_s;
      locked_r    <= (state_nxt_s == ST_LOCKED);
      error_r     <= err_evt_s;
      if (err_evt_s) begin
        last_bad_r <= counter_in;
        last_exp_r <= exp_s;
      end else begin
        last_bad_r <= last_bad_r;
        last_exp_r <= last_exp_r;
      end
    end
  end

  sat_counter #(
    .width(ERR_W)
  ) u_err_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (err_evt_s),
    .clr  (1'b0),
    .count(error_count)
  );

  assign locked   = locked_r;
  assign error    = error_r;
  assign last_bad = last_bad_r;
  assign last_exp = last_exp_r;

endmodule

// File: tb/tb_counter_checker.sv
// Directed, table-driven bench for counter_checker with default parameters,
// plus hand-written sequences for async reset and error-count saturation.
module tb_counter_checker;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] counter_in;
  logic       resync;
  logic       locked;
  logic       error;
  logic [7:0] error_count;
  logic [3:0] last_bad;
  logic [3:0] last_exp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic [3:0] cin;
    logic       rs;
    logic       locked;
    logic       err;
    logic [7:0] cnt;
    logic [3:0] lb;
    logic [3:0] le;
  } vec_t;

  vec_t vecs[$];

  counter_checker dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .counter_in (counter_in),
    .resync     (resync),
    .locked     (locked),
    .error      (error),
    .error_count(error_count),
    .last_bad   (last_bad),
    .last_exp   (last_exp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void add(input logic en, input logic [3:0] cin, input logic rs,
                              input logic lk, input logic er, input logic [7:0] cnt,
                              input logic [3:0] lb, input logic [3:0] le);
    vec_t v;
    v.en = en; v.cin = cin; v.rs = rs; v.locked = lk; v.err = er;
    v.cnt = cnt; v.lb = lb; v.le = le;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic step(input logic en, input logic [3:0] cin, input logic rs);
    enable     = en;
    counter_in = cin;
    resync     = rs;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_all(input string tag, input logic lk, input logic er,
                           input logic [7:0] cnt, input logic [3:0] lb, input logic [3:0] le);
    check({tag, ".locked"}, {31'd0, locked}, {31'd0, lk});
    check({tag, ".error"}, {31'd0, error}, {31'd0, er});
    check({tag, ".error_count"}, {24'd0, error_count}, {24'd0, cnt});
    check({tag, ".last_bad"}, {28'd0, last_bad}, {28'd0, lb});
    check({tag, ".last_exp"}, {28'd0, last_exp}, {28'd0, le});
  endtask

  initial begin
    // Lock-in on a counting sequence, then hold at 7 with enable low.
    for (int i = 0; i < 7; i++) add(1'b1, 4'(i), 1'b0, (i >= 2), 1'b0, 8'd0, 4'd0, 4'd0);
    for (int i = 0; i < 10; i++) add(1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 8'd0, 4'd0, 4'd0);
    // 7 -> 8 jump with the previous enable low.
    add(1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 8'd1, 4'd8, 4'd7);
    add(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 8'd1, 4'd8, 4'd7);
    // Relock, then run through the 15 -> 0 wrap up to 5.
    for (int i = 10; i < 22; i++) add(1'b1, 4'(i % 16), 1'b0, 1'b1, 1'b0, 8'd1, 4'd8, 4'd7);
    // Locked at 5, drive 9 instead of 6; relock after two good samples.
    add(1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 8'd2, 4'd9, 4'd6);
    add(1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 8'd2, 4'd9, 4'd6);
    add(1'b1, 4'd11, 1'b0, 1'b1, 1'b0, 8'd2, 4'd9, 4'd6);
    // Mismatch together with resync: no error, then reseed and relock.
    add(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 8'd2, 4'd9, 4'd6);
    add(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 8'd2, 4'd9, 4'd6);
    add(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 8'd2, 4'd9, 4'd6);
    add(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 8'd2, 4'd9, 4'd6);

    reset      = 1'b1;
    enable     = 1'b0;
    counter_in = 4'd0;
    resync     = 1'b0;
    repeat (2) @(negedge clock);
    check_all("reset", 1'b0, 1'b0, 8'd0, 4'd0, 4'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].cin, vecs[i].rs);
      check_all($sformatf("vec%0d", i), vecs[i].locked, vecs[i].err, vecs[i].cnt,
                vecs[i].lb, vecs[i].le);
    end

    // Mid-run reset clears outputs before any clock edge.
    #2 reset = 1'b1;
    #1 check_all("async_reset", 1'b0, 1'b0, 8'd0, 4'd0, 4'd0);
    @(negedge clock);
    reset = 1'b0;
    step(1'b1, 4'd9, 1'b0);
    check_all("post_reset_seed", 1'b0, 1'b0, 8'd0, 4'd0, 4'd0);
    step(1'b1, 4'd10, 1'b0);
    check("post_reset_locking", {31'd0, locked}, 32'd0);
    step(1'b1, 4'd11, 1'b0);
    check("post_reset_locked", {31'd0, locked}, 32'd1);

    // 300 mismatches, each after a reseed and relock.
    for (int k = 0; k < 300; k++) begin
      step(1'b1, 4'd0, 1'b1);
      step(1'b1, 4'd0, 1'b0);
      step(1'b1, 4'd1, 1'b0);
      step(1'b1, 4'd2, 1'b0);
      step(1'b1, 4'd7, 1'b0);
      check($sformatf("sat%0d.error", k), {31'd0, error}, 32'd1);
      check($sformatf("sat%0d.count", k), {24'd0, error_count}, (k + 1 > 255) ? 32'd255 : 32'(k + 1));
    end
    step(1'b1, 4'd8, 1'b0);
    check("sat_final.error", {31'd0, error}, 32'd0);
    check("sat_final.count", {24'd0, error_count}, 32'd255);
    check("sat_final.last_exp", {28'd0, last_exp}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 Parameter CNT_W, default 4: width of the observed counter value.
REQ-002 Parameter ERR_W, default 8: width of the error counter.
REQ-003 Parameter LOCK_N, default 2: consecutive correct predictions needed to declare lock; legal range 1..15.
REQ-004 clock  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  count enable, in the same form as driven to the counter under check.
REQ-007 counter_in  input  CNT_W  counter value observed from the counter under check.
REQ-008 resync  input  1  synchronous request to drop lock and reseed.
REQ-009 locked  output  1  high while the checker is tracking the sequence.
REQ-010 error  output  1  one-cycle pulse per detected mismatch.
REQ-011 error_count  output  ERR_W  saturating count of mismatches.
REQ-012 last_bad  output  CNT_W  counter_in value at the most recent mismatch.
REQ-013 last_exp  output  CNT_W  predicted value at the most recent mismatch.

Function
REQ-014 The checker SHALL sample counter_in and enable on every rising clock edge.
REQ-015 Prediction rule: expected = prev + 1 mod 2^CNT_W if the previously sampled enable was 1; otherwise expected = prev.
REQ-016 prev SHALL be loaded with each sample of counter_in.
REQ-017 The state machine SHALL use three states: SEED, LOCKING and LOCKED.
REQ-018 SEED: capture the sample into prev, clear the match count, then go to LOCKING; no comparison is made.
REQ-019 LOCKING, on a match: increment the match count; on reaching LOCK_N, go to LOCKED.
REQ-020 LOCKING, on a mismatch: clear the match count and stay in LOCKING; error SHALL NOT assert.
REQ-021 LOCKED, on a match: stay in LOCKED.
REQ-022 LOCKED, on a mismatch: pulse error, update last_bad and last_exp, increment error_count, clear the match count, go to LOCKING.
REQ-023 Wrap-around 2^CNT_W-1 -> 0 with the previous enable at 1 SHALL count as a match.
REQ-024 Any value change while the previous enable was 0 SHALL count as a mismatch.
REQ-025 All outputs SHALL be registered; error, locked and the last_* outputs reflect the sample taken one edge earlier (latency 1).
REQ-026 error_count SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-027 resync=1 SHALL force SEED on the next edge, override any mismatch in the same cycle (no error, no count update), and deassert locked on that edge.
REQ-028 locked SHALL be 1 exactly while the state is LOCKED.

Reset
REQ-029 While reset is high, the checker SHALL asynchronously set: state=SEED, prev=0, match count=0, locked=0, error=0, error_count=0, last_bad=0, last_exp=0.
REQ-030 Reset asserted mid-operation SHALL discard lock and history; the first edge after release behaves as SEED.

Structure
REQ-031 A package counter_checker_pkg SHALL hold the state enumeration and the default CNT_W, ERR_W and LOCK_N constants.
REQ-032 The saturating error counter SHALL be a sub-module sat_counter (parameter width; inputs clock, reset, inc, clr; output count).

Verification
REQ-033 Reset, then enable=1 with a correct 4-bit counter -> locked=1 by the 4th edge after reset release, error never asserts, error_count=0.
REQ-034 Locked, counter_in goes 14 -> 15 -> 0 -> 1 with enable=1 -> no error and locked stays 1.
REQ-035 Locked at value 5, enable=1, counter_in driven to 9 instead of 6 -> error high for exactly 1 cycle, last_bad=9, last_exp=6, error_count=1, locked=0, relock after LOCK_N further correct samples.
REQ-036 Locked, enable=0 with counter_in held at 7 for 10 cycles -> no error; then a 7 -> 8 jump with the previous enable=0 -> error, last_exp=7.
REQ-037 Force 300 mismatches with reseeding between them -> error_count holds at 255.
REQ-038 Mismatch and resync in the same cycle -> no error and count unchanged; reset pulse mid-run -> all outputs 0 immediately, without waiting for a clock edge.
